// File: rtl/lfsr_ctrl.sv
// lfsr_ctrl: controller that loads a seed into a Fibonacci-style LFSR and
// then clocks it a requested number of steps.
//
// Ports:
//   clk      - clock, all state updates on rising edge
//   rst      - asynchronous active-high reset
//   start    - run request, sampled only in IDLE
//   seed     - initial LFSR value, captured when start is accepted
//   count    - number of shift steps, captured when start is accepted
//   stop     - abort request, honoured only in RUN
//   sel      - load/feedback mux select (0 = seed, 1 = shifted value)
//   q        - current LFSR state
//   busy     - high in LOAD and RUN
//   step     - high in each cycle whose closing edge shifts q
//   done     - one-cycle pulse in DONE
//   seed_err - one-cycle pulse after a start with an all-zero seed
module lfsr_ctrl #(
  parameter int unsigned          WIDTH = 4,
  parameter logic [WIDTH-1:0]     TAPS  = 4'b1100,
  parameter int unsigned          CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [CW-1:0]    count,
  input  logic             stop,
  output logic             sel,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             step,
  output logic             done,
  output logic             seed_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] seed_r_q, seed_r_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic             seed_err_q, seed_err_d;

  logic             fb;
  logic [WIDTH-1:0] shifted;
  logic             load_en;

  assign fb      = ^(lfsr_q & TAPS);
  assign shifted = {lfsr_q[WIDTH-2:0], fb};

  always_comb begin
    state_d    = state_q;
    seed_r_d   = seed_r_q;
    rem_d      = rem_q;
    lfsr_d     = lfsr_q;
    seed_err_d = 1'b0;
    load_en    = 1'b0;
    sel        = 1'b0;
    busy       = 1'b0;
    step       = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (seed != '0) begin
            seed_r_d = seed;
            rem_d    = count;
            state_d  = LOAD;
          end else begin
            seed_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        busy    = 1'b1;
        load_en = 1'b1;
        state_d = (rem_q == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        sel  = 1'b1;
        // An abort freezes both q and rem; only the state moves on.
        if (stop) begin
          state_d = DONE;
        end else begin
          step    = 1'b1;
          load_en = 1'b1;
          rem_d   = rem_q - CW'(1);
          if (rem_q == CW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load_en) lfsr_d = sel ? shifted : seed_r_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lfsr_q     <= '0;
      seed_r_q   <= '0;
      rem_q      <= '0;
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      seed_r_q   <= seed_r_d;
      rem_q      <= rem_d;
      seed_err_q <= seed_err_d;
    end
  end

  assign q        = lfsr_q;
  assign seed_err = seed_err_q;

endmodule

// File: doc/lfsr_ctrl.md
LFSR_CTRL -- requirements
Module: lfsr_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: LFSR state width (>=3).
REQ-002 Parameter TAPS, default 4'b1100: feedback tap mask; bit i set means q[i] enters feedback XOR.
REQ-003 Parameter CW, default 8: step-count width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request a run; sampled only in IDLE.
REQ-007 seed  input  WIDTH  initial LFSR value; captured when start is accepted.
REQ-008 count  input  CW  number of shift steps to execute; captured when start is accepted.
REQ-009 stop  input  1  abort request; honoured only in RUN.
REQ-010 sel  output  1  select line driven to the 2:1 load/feedback mux per bit: 0 = seed, 1 = shifted value.
REQ-011 q  output  WIDTH  current LFSR state.
REQ-012 busy  output  1  high in LOAD and RUN.
REQ-013 step  output  1  high in each cycle whose closing edge performs a shift.
REQ-014 done  output  1  one-cycle pulse in DONE.
REQ-015 seed_err  output  1  one-cycle pulse on rejected start.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, LOAD, RUN, DONE.
REQ-017 Feedback: fb = XOR-reduce(q & TAPS); shifted value = {q[WIDTH-2:0], fb}.
REQ-018 The register input SHALL be mux(seed_r, shifted, sel); q updates only in LOAD and RUN and holds in IDLE and DONE.
REQ-019 IDLE: if start=1 and seed!=0, latch seed_r<=seed and rem<=count, then go to LOAD.
REQ-020 IDLE: if start=1 and seed==0, stay in IDLE, pulse seed_err for the next cycle, and leave q unchanged.
REQ-021 LOAD: sel=0; at the closing edge, q<=seed_r; go to DONE if rem==0, otherwise go to RUN.
REQ-022 RUN: sel=1, step=1; each edge shifts q once and decrements rem; the edge where rem==1 moves to DONE.
REQ-023 RUN with stop=1: no shift at that edge, step=0, rem is left as is, go to DONE.
REQ-024 DONE: done=1 for exactly one cycle, then go to IDLE; q holds its final value.
REQ-025 start in LOAD, RUN or DONE SHALL be ignored, with no queuing.
REQ-026 Latency: with start accepted at edge E0, q=seed after E1, N shifts occur at E2..E(N+1), and done is high in the cycle after E(N+1).
REQ-027 rem SHALL be CW bits wide, count=0 is legal (load only), and no wrap below zero is possible.
REQ-028 In IDLE and DONE, sel=0 and step=0.

Reset
REQ-029 When rst=1, independent of clk, the block SHALL force state=IDLE, q=0, seed_r=0, rem=0, sel=0, busy=0, step=0, done=0, seed_err=0.
REQ-030 Reset asserted mid-RUN SHALL abort immediately with no done pulse; after release, the block waits in IDLE for a new start.

Verification
REQ-031 WIDTH=4, seed=0001, count=4 -> q sequence 0001, 0010, 0100, 1001, 0011; done one cycle after the 4th step; step high for exactly 4 cycles.
REQ-032 seed=0001, count=15 -> q returns to 0001 after step 15, with no intermediate repeat (maximal period 15).
REQ-033 start with seed=0000 -> seed_err pulses once, busy stays 0, q unchanged.
REQ-034 seed=1000, count=10, stop asserted in the 3rd RUN cycle -> exactly 2 shifts (1000, 0001, 0010), then done pulse.
REQ-035 count=0, seed=0110 -> q=0110, zero step cycles, done 2 cycles after start is accepted; a start pulse during RUN of another run is ignored.
REQ-036 rst asserted asynchronously mid-RUN (between edges) -> all outputs are at reset values before the next edge, and no done pulse occurs.
